// File: rtl/triangle_raster_scan_if.sv
// Triangle input / fragment output bundle for triangle_raster_scan.
// Optional macro: RASTER_FRAG_COUNT_EN adds the 20-bit frag_count signal.
// Triangle layout, MSB first: px,py,pz,qx,qy,qz,rx,ry,rz (signed 16-bit each).
interface triangle_raster_scan_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic [143:0]        tri_in;
  logic                tri_valid;
  logic                tri_ready;
  logic signed [15:0]  frag_x;
  logic signed [15:0]  frag_y;
  logic [ADDR_W-1:0]   frag_addr;
  logic [143:0]        frag_tri;
  logic                frag_valid;
  logic                frag_ready;
  logic                tri_done;
  logic                busy;
`ifdef RASTER_FRAG_COUNT_EN
  logic [19:0]         frag_count;
`endif

  // Upstream/downstream side (drives triangles, accepts fragments)
  modport master (
    output tri_in, tri_valid, frag_ready,
`ifdef RASTER_FRAG_COUNT_EN
    input  frag_count,
`endif
    input  tri_ready, frag_x, frag_y, frag_addr, frag_tri, frag_valid,
           tri_done, busy
  );

  // Rasterizer side
  modport slave (
    input  tri_in, tri_valid, frag_ready,
`ifdef RASTER_FRAG_COUNT_EN
    output frag_count,
`endif
    output tri_ready, frag_x, frag_y, frag_addr, frag_tri, frag_valid,
           tri_done, busy
  );
endinterface

// File: rtl/triangle_raster_scan.sv
// Rasterizer front end: walks a triangle's screen-clipped bounding box in
// row-major order and emits one fragment per covered pixel.
// Optional macro: RASTER_FRAG_COUNT_EN adds a per-triangle fragment counter.
module triangle_raster_scan #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ADDR_W = 19
) (
  input logic                  clk,
  input logic                  n_rst,
  triangle_raster_scan_if.slave bus
);

  // One guard bit above the 34-bit products so extreme inputs cannot wrap
  localparam int unsigned E_W = 35;
  localparam logic signed [15:0] X_MAX = 16'(WIDTH - 1);
  localparam logic signed [15:0] Y_MAX = 16'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  W_A   = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t              state;
  logic [143:0]        tri_q;
  logic signed [15:0]  minx, maxx, maxy, x, y;
  logic [ADDR_W-1:0]   row_base, addr;
  logic                scan_end;
  logic signed [15:0]  fx, fy;
  logic [ADDR_W-1:0]   faddr;
  logic [143:0]        ftri;
  logic                fvalid, tdone, tready, busy_q;
`ifdef RASTER_FRAG_COUNT_EN
  logic [19:0]         fcount;
`endif

  function automatic logic signed [E_W-1:0] edge_fn(
    input logic signed [15:0] ax, ay, bx, by, px, py);
    logic signed [E_W-1:0] dx, dy, ex, ey;
    dx = E_W'(bx) - E_W'(ax);
    dy = E_W'(by) - E_W'(ay);
    ex = E_W'(px) - E_W'(ax);
    ey = E_W'(py) - E_W'(ay);
    return dx * ey - dy * ex;
  endfunction

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [15:0] clamp(input logic signed [15:0] v, lim);
    if (v[15])    return 16'sd0;
    else if (v > lim) return lim;
    else          return v;
  endfunction

  logic signed [15:0]  px, py, qx, qy, rx, ry;
  logic signed [15:0]  bx_lo, bx_hi, by_lo, by_hi;
  logic signed [15:0]  cx_lo, cx_hi, cy_lo, cy_hi;
  logic signed [E_W-1:0] area, e0, e1, e2;
  logic                off_screen, covered, last_px, out_free;

  assign px = tri_q[143:128];
  assign py = tri_q[127:112];
  assign qx = tri_q[95:80];
  assign qy = tri_q[79:64];
  assign rx = tri_q[47:32];
  assign ry = tri_q[31:16];

  // Setup-time bounding box, clipping and signed area
  assign bx_lo = min3(px, qx, rx);
  assign bx_hi = max3(px, qx, rx);
  assign by_lo = min3(py, qy, ry);
  assign by_hi = max3(py, qy, ry);
  assign cx_lo = clamp(bx_lo, X_MAX);
  assign cx_hi = clamp(bx_hi, X_MAX);
  assign cy_lo = clamp(by_lo, Y_MAX);
  assign cy_hi = clamp(by_hi, Y_MAX);
  assign off_screen = bx_hi[15] || (bx_lo > X_MAX) || by_hi[15] || (by_lo > Y_MAX);
  assign area = edge_fn(px, py, qx, qy, rx, ry);

  // Per-pixel coverage test, accepting both windings and edge pixels
  assign e0 = edge_fn(px, py, qx, qy, x, y);
  assign e1 = edge_fn(qx, qy, rx, ry, x, y);
  assign e2 = edge_fn(rx, ry, px, py, x, y);
  assign covered = (!e0[E_W-1] && !e1[E_W-1] && !e2[E_W-1]) ||
                   ((e0[E_W-1] || e0 == '0) && (e1[E_W-1] || e1 == '0) &&
                    (e2[E_W-1] || e2 == '0));
  assign last_px  = (x == maxx) && (y == maxy);
  assign out_free = !fvalid || bus.frag_ready;

  // Control FSM, scan counters and registered fragment outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      tri_q    <= '0;
      minx     <= '0;
      maxx     <= '0;
      maxy     <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr     <= '0;
      scan_end <= 1'b0;
      fx       <= '0;
      fy       <= '0;
      faddr    <= '0;
      ftri     <= '0;
      fvalid   <= 1'b0;
      tdone    <= 1'b0;
      tready   <= 1'b1;
      busy_q   <= 1'b0;
`ifdef RASTER_FRAG_COUNT_EN
      fcount   <= '0;
`endif
    end else begin
      tdone <= 1'b0;
`ifdef RASTER_FRAG_COUNT_EN
      if (fvalid && bus.frag_ready) fcount <= fcount + 20'd1;
`endif
      case (state)
        IDLE: begin
          if (bus.tri_valid) begin
            tri_q  <= bus.tri_in;
            tready <= 1'b0;
            busy_q <= 1'b1;
            state  <= SETUP;
`ifdef RASTER_FRAG_COUNT_EN
            fcount <= '0;
`endif
          end
        end
        SETUP: begin
          if (area == '0 || off_screen) begin
            state <= DONE;
            tdone <= 1'b1;
          end else begin
            minx     <= cx_lo;
            maxx     <= cx_hi;
            maxy     <= cy_hi;
            x        <= cx_lo;
            y        <= cy_lo;
            row_base <= ADDR_W'($unsigned(cy_lo)) * W_A;
            addr     <= ADDR_W'($unsigned(cy_lo)) * W_A + ADDR_W'($unsigned(cx_lo));
            scan_end <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (out_free) begin
            if (scan_end) begin
              fvalid <= 1'b0;
              tdone  <= 1'b1;
              state  <= DONE;
            end else begin
              fvalid <= covered;
              if (covered) begin
                fx    <= x;
                fy    <= y;
                faddr <= addr;
                ftri  <= tri_q;
              end
              if (last_px) begin
                scan_end <= 1'b1;
              end else if (x == maxx) begin
                x        <= minx;
                y        <= y + 16'sd1;
                row_base <= row_base + W_A;
                addr     <= row_base + W_A + ADDR_W'($unsigned(minx));
              end else begin
                x    <= x + 16'sd1;
                addr <= addr + ADDR_W'(1);
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          tready <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tri_ready  = tready;
  assign bus.frag_x     = fx;
  assign bus.frag_y     = fy;
  assign bus.frag_addr  = faddr;
  assign bus.frag_tri   = ftri;
  assign bus.frag_valid = fvalid;
  assign bus.tri_done   = tdone;
  assign bus.busy       = busy_q;
`ifdef RASTER_FRAG_COUNT_EN
  assign bus.frag_count = fcount;
`endif

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Scoreboard bench for triangle_raster_scan: expected fragments are queued
// when a triangle is issued and popped as the DUT hands fragments over.
module tb_triangle_raster_scan;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  typedef struct {
    int           x;
    int           y;
    int           addr;
    logic [143:0] t;
  } frag_t;

  logic clk;
  logic n_rst;

  triangle_raster_scan_if #(.ADDR_W(19)) bus ();

  triangle_raster_scan #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(19)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frag_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    done_cnt = 0;
  int    acc_cnt  = 0;
  int    exp_n    = 0;
  int    rdy_mode = 0;
  bit    stall_done = 1'b0;
  int    stall_left = 0;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] mk_tri(input int ax, ay, az, bx, by, bz,
                                          input int cx, cy, cz);
    return {16'(ax), 16'(ay), 16'(az), 16'(bx), 16'(by), 16'(bz),
            16'(cx), 16'(cy), 16'(cz)};
  endfunction

  task automatic push_exp(input int x, input int y, input int addr,
                          input logic [143:0] t);
    frag_t f;
    f.x = x; f.y = y; f.addr = addr; f.t = t;
    exp_q.push_back(f);
  endtask

  // Reference coverage model over the clipped bounding box
  task automatic push_model(input int ax, ay, bx, by, cx, cy, input logic [143:0] t);
    longint a, e0, e1, e2;
    int lox, hix, loy, hiy;
    a = longint'(bx - ax) * (cy - ay) - longint'(by - ay) * (cx - ax);
    if (a == 0) return;
    lox = ax; if (bx < lox) lox = bx; if (cx < lox) lox = cx;
    hix = ax; if (bx > hix) hix = bx; if (cx > hix) hix = cx;
    loy = ay; if (by < loy) loy = by; if (cy < loy) loy = cy;
    hiy = ay; if (by > hiy) hiy = by; if (cy > hiy) hiy = cy;
    if (lox < 0) lox = 0;
    if (loy < 0) loy = 0;
    if (hix > WIDTH - 1)  hix = WIDTH - 1;
    if (hiy > HEIGHT - 1) hiy = HEIGHT - 1;
    for (int yy = loy; yy <= hiy; yy++)
      for (int xx = lox; xx <= hix; xx++) begin
        e0 = longint'(bx - ax) * (yy - ay) - longint'(by - ay) * (xx - ax);
        e1 = longint'(cx - bx) * (yy - by) - longint'(cy - by) * (xx - bx);
        e2 = longint'(ax - cx) * (yy - cy) - longint'(ay - cy) * (xx - cx);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
          push_exp(xx, yy, yy * WIDTH + xx, t);
      end
  endtask

  task automatic push_tri1(input logic [143:0] t);
    int xs[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    int ys[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int as[10] = '{0, 1, 2, 3, 640, 641, 642, 1280, 1281, 1920};
    for (int i = 0; i < 10; i++) push_exp(xs[i], ys[i], as[i], t);
  endtask

  task automatic push_clip(input logic [143:0] t);
    int xs[6] = '{0, 1, 2, 0, 1, 0};
    int ys[6] = '{0, 0, 0, 1, 1, 2};
    int as[6] = '{0, 1, 2, 640, 641, 1280};
    for (int i = 0; i < 6; i++) push_exp(xs[i], ys[i], as[i], t);
  endtask

  // Downstream ready driver: always-ready, random, or a 5-cycle stall at (2,0)
  initial begin
    bus.frag_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        bus.frag_ready = 1'($urandom_range(0, 1));
      end else if (rdy_mode == 2) begin
        if (stall_left == 0 && !stall_done && bus.frag_valid &&
            bus.frag_x == 16'sd2 && bus.frag_y == 16'sd0) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
        if (stall_left > 0) begin
          bus.frag_ready = 1'b0;
          stall_left--;
        end else begin
          bus.frag_ready = 1'b1;
        end
      end else begin
        bus.frag_ready = 1'b1;
      end
    end
  end

  // Fragment monitor: scoreboard pop, range checks and stall stability
  logic               prev_stall = 1'b0;
  logic signed [15:0] prev_x, prev_y;
  logic [18:0]        prev_addr;
  logic [143:0]       prev_tri;

  always @(negedge clk) begin
    frag_t f;
    if (n_rst) begin
      if (prev_stall) begin
        check("hold_valid", longint'(bus.frag_valid), 1);
        check("hold_x", longint'(bus.frag_x), longint'(prev_x));
        check("hold_y", longint'(bus.frag_y), longint'(prev_y));
        check("hold_addr", longint'(bus.frag_addr), longint'(prev_addr));
        check("hold_tri", longint'(bus.frag_tri == prev_tri), 1);
      end
      if (bus.frag_valid && bus.frag_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_frag", 1, 0);
        end else begin
          f = exp_q.pop_front();
          check("frag_x", longint'(bus.frag_x), f.x);
          check("frag_y", longint'(bus.frag_y), f.y);
          check("frag_addr", longint'(bus.frag_addr), f.addr);
          check("frag_tri", longint'(bus.frag_tri == f.t), 1);
        end
      end
      if (bus.tri_done) done_cnt++;
      prev_stall = bus.frag_valid && !bus.frag_ready;
      prev_x    = bus.frag_x;
      prev_y    = bus.frag_y;
      prev_addr = bus.frag_addr;
      prev_tri  = bus.frag_tri;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offer a triangle once the block is ready; returns #1 after the accept edge
  task automatic start_tri(input logic [143:0] t);
    int i;
    exp_n = exp_q.size();
    for (i = 0; i < 50 && !bus.tri_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.tri_ready) check("ready_timeout", 0, 1);
    bus.tri_in    = t;
    bus.tri_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tri_valid = 1'b0;
  endtask

  // Wait for the scan to finish and check the end-of-triangle state
  task automatic wait_done(input string tag, output int lat);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      lat++;
      if (bus.tri_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, longint'(seen), 1);
`ifdef RASTER_FRAG_COUNT_EN
    check({tag, "_count"}, longint'(bus.frag_count), exp_n);
`endif
    @(negedge clk);
    check({tag, "_ready_back"}, longint'(bus.tri_ready), 1);
    check({tag, "_busy_low"}, longint'(bus.busy), 0);
    check({tag, "_leftover"}, longint'(exp_q.size()), 0);
    check({tag, "_done_pulses"}, longint'(done_cnt - d0), 1);
`ifdef RASTER_FRAG_COUNT_EN
    check({tag, "_count_hold"}, longint'(bus.frag_count), exp_n);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tri_ready"}, longint'(bus.tri_ready), 1);
    check({tag, "_frag_valid"}, longint'(bus.frag_valid), 0);
    check({tag, "_tri_done"}, longint'(bus.tri_done), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_frag_x"}, longint'(bus.frag_x), 0);
    check({tag, "_frag_y"}, longint'(bus.frag_y), 0);
    check({tag, "_frag_addr"}, longint'(bus.frag_addr), 0);
    check({tag, "_frag_tri"}, longint'(bus.frag_tri == '0), 1);
`ifdef RASTER_FRAG_COUNT_EN
    check({tag, "_frag_count"}, longint'(bus.frag_count), 0);
`endif
  endtask

  initial begin
    logic [143:0] t;
    int lat;
    int c[6];
    n_rst = 1'b0;
    bus.tri_valid = 1'b0;
    bus.tri_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic right triangle
    t = mk_tri(0, 0, 5, 3, 0, 5, 0, 3, 5);
    push_tri1(t);
    start_tri(t);
    wait_done("tri1", lat);

    // Opposite winding
    t = mk_tri(0, 0, 5, 0, 3, 5, 3, 0, 5);
    push_tri1(t);
    start_tri(t);
    wait_done("wind", lat);

    // Clipped at x=0
    t = mk_tri(-2, 0, 1, 2, 0, 1, -2, 4, 1);
    push_clip(t);
    start_tri(t);
    wait_done("clip", lat);

    // Degenerate (zero area)
    t = mk_tri(0, 0, 0, 1, 1, 0, 2, 2, 0);
    start_tri(t);
    wait_done("degen", lat);
    check("degen_latency", longint'(lat <= 3), 1);

    // Fully off-screen
    t = mk_tri(700, 10, 0, 710, 10, 0, 700, 20, 0);
    start_tri(t);
    wait_done("offscr", lat);
    check("offscr_latency", longint'(lat <= 3), 1);

    // Backpressure: 5-cycle stall while (2,0) is presented
    rdy_mode = 2;
    stall_done = 1'b0;
    t = mk_tri(0, 0, 5, 3, 0, 5, 0, 3, 5);
    push_tri1(t);
    start_tri(t);
    wait_done("stall", lat);
    check("stall_happened", longint'(stall_done), 1);
    rdy_mode = 0;

    // Small random triangles under random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) c[j] = int'($urandom_range(0, 31)) - 6;
      t = mk_tri(c[0], c[1], k, c[2], c[3], k, c[4], c[5], k);
      push_model(c[0], c[1], c[2], c[3], c[4], c[5], t);
      start_tri(t);
      wait_done("rand", lat);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset mid-scan after four fragments
    t = mk_tri(0, 0, 5, 3, 0, 5, 0, 3, 5);
    push_tri1(t);
    acc_cnt = 0;
    start_tri(t);
    for (int i = 0; i < 200 && acc_cnt < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("midscan_frags", longint'(acc_cnt), 4);
    n_rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", longint'(bus.tri_ready), 1);
    t = mk_tri(-2, 0, 7, 2, 0, 7, -2, 4, 7);
    push_clip(t);
    start_tri(t);
    wait_done("post_rst", lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/triangle_raster_scan.md
Name: triangle_raster_scan

Overview:
- Rasterizer front end: accepts one screen-space Triangle3D per handshake and walks its screen-clipped bounding box in row-major order.
- Emits one fragment per covered pixel: x, y, framebuffer address, and the owning triangle passed through.
- Downstream stage performs z_interpolation per fragment and z-buffer/colour write.
- Upstream is the transform/projection stage.

Parameters:
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in pixels
- ADDR_W, 19, framebuffer address width (WIREFRAME_ADDR_SIZE)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- tri_in  in  144  Triangle3D (p,q,r; each x,y,z signed 16-bit shortint)
- tri_valid  in  1  tri_in valid
- tri_ready  out  1  block can accept a triangle
- frag_x  out  16  fragment x, signed, always in 0..WIDTH-1
- frag_y  out  16  fragment y, signed, always in 0..HEIGHT-1
- frag_addr  out  ADDR_W  frag_y*WIDTH + frag_x
- frag_tri  out  144  triangle owning the fragment
- frag_valid  out  1  fragment valid
- frag_ready  in  1  downstream accepts fragment
- tri_done  out  1  one-cycle pulse when a triangle's scan completes
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, n_rst low): state IDLE; tri_ready=1; frag_valid=0; tri_done=0; busy=0; frag_x/frag_y/frag_addr/frag_tri=0. A reset mid-scan abandons the triangle; no further fragments are emitted.
- IDLE: tri_ready=1. On tri_valid&&tri_ready, latch tri_in and go to SETUP. tri_ready=0 in every other state.
- SETUP (1 cycle):
  - Bbox = signed min/max of x and y; clamp to [0,WIDTH-1] x [0,HEIGHT-1].
  - Compute 2*signed area A = (qx-px)*(ry-py) - (qy-py)*(rx-px), 34-bit signed.
  - If A==0, or the bbox lies fully off-screen (maxx<0, minx>WIDTH-1, maxy<0 or miny>HEIGHT-1), go to DONE.
  - Otherwise go to SCAN at (minx_c, miny_c).
- SCAN: evaluates one candidate pixel per cycle while the output register is free.
  - Edge functions, exact 34-bit signed:
    - E0 = (qx-px)*(y-py) - (qy-py)*(x-px)
    - E1 = (rx-qx)*(y-qy) - (ry-qy)*(x-qx)
    - E2 = (px-rx)*(y-ry) - (py-ry)*(x-rx)
  - Covered iff all E>=0 or all E<=0. Both windings are accepted, and edge pixels are inclusive.
  - Covered pixels load the output register with frag_valid=1. Uncovered pixels cost one cycle and produce no output.
  - Step: x+1; at maxx_c, x=minx_c and y+1. Address advances incrementally (row base += WIDTH).
  - After the last bbox pixel is evaluated and its fragment (if any) is accepted, go to DONE.
- Backpressure: while frag_valid&&!frag_ready, all frag_* outputs hold stable and scanning stalls. No fragment is lost or duplicated. frag_valid may only drop after acceptance.
- DONE (1 cycle): tri_done=1, then IDLE. A new triangle is accepted no earlier than the cycle after tri_done.
- Fragment count per triangle is at most the bbox area. Latency from triangle accept to first evaluation is 2 cycles.

Optional Feature:
- RASTER_FRAG_COUNT_EN defined:
  - Adds output frag_count (20-bit).
  - Reset 0; cleared on triangle accept; incremented per accepted fragment.
  - Holds the final count at and after tri_done until the next accept.
- RASTER_FRAG_COUNT_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- p(0,0,5) q(3,0,5) r(0,3,5), frag_ready=1 -> exactly 10 fragments, in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(0,2)(1,2)(0,3), addrs 0,1,2,3,640,641,642,1280,1281,1920; tri_done once; count=10 if enabled.
- Same triangle with q and r swapped -> identical 10 fragments (winding independence).
- p(-2,0) q(2,0) r(-2,4) -> clipped to x>=0; exactly 6 fragments (0,0)(1,0)(2,0)(0,1)(1,1)(0,2); no negative coordinates.
- Degenerate p(0,0) q(1,1) r(2,2), and off-screen p(700,10) q(710,10) r(700,20) -> 0 fragments, tri_done within 3 cycles of accept, tri_ready back to 1.
- Test-1 triangle with frag_ready held low for 5 cycles at fragment (2,0) -> outputs stable throughout; sequence and count unchanged.
- n_rst low during SCAN after 4 fragments -> all outputs at reset values; after release tri_ready=1 and a new triangle scans correctly from its start.
